lsu_mm: RTL and testbench
=========================

LSU_MM -- requirements
Module: lsu_mm

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 256: data-region size in 32-bit words, power of two, at least 64.
REQ-002 SHALL have parameter IO_OUT_NUM, default 11: number of output peripheral words, 1..64.
REQ-003 SHALL have parameter MEM_LATENCY, default 2: cycles from request acceptance to response valid, at least 1.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid_i, input, 1 bit: request valid.
REQ-007 SHALL have port req_ready_o, output, 1 bit: request accepted this cycle when high together with req_valid_i.
REQ-008 SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr_i, input, 32 bits: word address.
REQ-010 SHALL have ports req_wdata_i (input, 32 bits, store data) and req_be_i (input, 4 bits, byte-lane enables).
REQ-011 SHALL have ports rsp_valid_o (output, 1 bit) and rsp_ready_i (input, 1 bit): response handshake.
REQ-012 SHALL have ports rsp_rdata_o (output, 32 bits, load data) and rsp_err_o (output, 1 bit, access error).
REQ-013 SHALL have ports io_sw_i (input, 32 bits, switches) and io_out_o (output, IO_OUT_NUM*32 bits, peripheral words; word k at bits [32k+31:32k]).

Function
REQ-014 SHALL decode the captured address into four regions:
  - data: [0, DATA_DEPTH)
  - output: [DATA_DEPTH, DATA_DEPTH+64)
  - input: [DATA_DEPTH+64, DATA_DEPTH+128)
  - reserved: everything else
REQ-015 SHALL implement FSM IDLE, WAIT, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-016 SHALL, on acceptance in IDLE, capture we/addr/wdata/be and go to RESP if MEM_LATENCY=1, else to WAIT with a counter loaded to MEM_LATENCY-2.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the edge where it reads 0; rsp_valid_o therefore rises exactly MEM_LATENCY cycles after the accept edge.
REQ-018 SHALL commit a store, and sample load data, on the edge entering RESP (the commit edge).
REQ-019 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable in RESP until rsp_ready_i=1, then return to IDLE on that edge.
REQ-020 SHALL NOT accept a new request on the RESP-exit edge; the earliest next accept is one cycle later.
REQ-021 SHALL return load data by region:
  - data: stored word
  - output: peripheral register, or 0 for offset >= IO_OUT_NUM
  - input: {15'b0, io_sw_i[16:0]}, sampled at the commit edge
  - reserved: 0
REQ-022 SHALL write stores to the data or output region only; output offsets >= IO_OUT_NUM SHALL be dropped without error.
REQ-023 SHALL drive rsp_err_o=1 for any reserved-region access and for a store to the input region; errored stores SHALL modify nothing.
REQ-024 SHALL drive rsp_rdata_o=0 for store responses.
REQ-025 SHALL drive io_out_o continuously from the output registers, updating on the commit edge.
REQ-026 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-027 SHALL, while rst_i=1:
  - force the FSM to IDLE and the counter to 0
  - drive rsp_valid_o, rsp_rdata_o and rsp_err_o to 0
  - clear all output peripheral registers to 0
  - drive req_ready_o to 0
REQ-028 SHALL leave data-region contents unreset.
REQ-029 SHALL discard any in-flight request when reset is asserted mid-transaction; an uncommitted store SHALL NOT be written.
REQ-030 SHALL raise req_ready_o on the first clock edge after rst_i deasserts.

Configuration
REQ-031 SHALL, when LSU_BYTE_STORE_EN is defined, write only the byte lanes whose req_be_i bit is 1, in both the data and output regions; be=4'b0000 is then a no-op store with no error.
REQ-032 SHALL, when LSU_BYTE_STORE_EN is undefined, ignore req_be_i and write all 32 bits; loads always return full words in both configurations.

Verification
REQ-033 SHALL cover: MEM_LATENCY=2; store 0xDEADBEEF to addr 5, then load addr 5 -> rsp_valid_o 2 cycles after each accept, load rdata=0xDEADBEEF, err=0.
REQ-034 SHALL cover: store 0x12 to addr DATA_DEPTH+1 -> io_out_o word 1 = 0x12 from the commit edge; a later load of the same address returns 0x12.
REQ-035 SHALL cover: io_sw_i=0xFFFFFFFF, load addr DATA_DEPTH+64 -> rdata=0x0001FFFF; store to the same address -> err=1, memory unchanged.
REQ-036 SHALL cover: load addr 0x1000 -> rdata=0, err=1; rsp_ready_i held 0 for 3 cycles -> response held stable and req_ready_o=0 throughout.
REQ-037 SHALL cover: LSU_BYTE_STORE_EN defined, word at addr 7 = 0xAABBCCDD, store 0x11223344 with be=4'b0101 -> load returns 0xAA22CC44; undefined -> 0x11223344.
REQ-038 SHALL cover: rst_i pulsed while in WAIT during a store to addr 9 -> no response, addr 9 unchanged, io_out_o=0, req_ready_o=1 one edge after release.

Source files
------------

// File: rtl/lsu_mm.sv
// lsu_mm: fixed-latency load/store unit over a data RAM, output peripheral registers and a switch input window.
// Define LSU_BYTE_STORE_EN to make stores honour the req_be_i byte lanes.
module lsu_mm #(
    parameter int DATA_DEPTH  = 256,
    parameter int IO_OUT_NUM  = 11,
    parameter int MEM_LATENCY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [31:0]              req_addr_i,
    input  logic [31:0]              req_wdata_i,
    input  logic [3:0]               req_be_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [31:0]              rsp_rdata_o,
    output logic                     rsp_err_o,
    input  logic [31:0]              io_sw_i,
    output logic [IO_OUT_NUM*32-1:0] io_out_o
);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   out_q [IO_OUT_NUM];
    logic [31:0]   out_d [IO_OUT_NUM];
    logic [31:0]   mem [DATA_DEPTH];

    logic          accept, commit, c_we, unused;
    logic [31:0]   c_addr, c_wdata, off, wmask, out_rd, mem_rd;
    logic [3:0]    c_be;
    logic          in_data, in_out, in_in, in_rsv;

    // rdy_q holds req_ready_o low until the first edge after reset release
    assign req_ready_o = (state_q == IDLE) && rdy_q;
    assign accept      = req_valid_i && req_ready_o;
    assign commit      = (accept && MEM_LATENCY == 1) || (state_q == WAIT && cnt_q == '0);
    assign rsp_valid_o = state_q == RESP;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // With single-cycle latency the commit edge is the accept edge, so use the live request
    assign c_we    = (state_q == IDLE) ? req_we_i    : we_q;
    assign c_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
    assign c_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
    assign c_be    = (state_q == IDLE) ? req_be_i    : be_q;

    assign off     = c_addr - 32'(DATA_DEPTH);
    assign in_data = c_addr < 32'(DATA_DEPTH);
    assign in_out  = !in_data && off < 32'd64;
    assign in_in   = !in_data && off >= 32'd64 && off < 32'd128;
    assign in_rsv  = !(in_data || in_out || in_in);
    assign mem_rd  = mem[c_addr[AW-1:0]];

`ifdef LSU_BYTE_STORE_EN
    assign wmask  = {{8{c_be[3]}}, {8{c_be[2]}}, {8{c_be[1]}}, {8{c_be[0]}}};
    assign unused = ^io_sw_i[31:17];
`else
    assign wmask  = '1;
    assign unused = ^{io_sw_i[31:17], c_be};
`endif

    always_comb begin
        out_rd = '0;
        for (int k = 0; k < IO_OUT_NUM; k++)
            if (in_out && off == 32'(k)) out_rd = out_q[k];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        out_d   = out_q;
        if (accept) begin
            we_d    = req_we_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            be_d    = req_be_i;
            state_d = (MEM_LATENCY == 1) ? RESP : WAIT;
            cnt_d   = (MEM_LATENCY == 1) ? '0 : CW'(MEM_LATENCY - 2);
        end else if (state_q == WAIT) begin
            state_d = (cnt_q == '0) ? RESP : WAIT;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end else if (state_q == RESP && rsp_ready_i) begin
            state_d = IDLE;
        end
        if (commit) begin
            rdata_d = c_we    ? '0 :
                      in_data ? mem_rd :
                      in_out  ? out_rd :
                      in_in   ? {15'b0, io_sw_i[16:0]} : '0;
            err_d   = in_rsv || (c_we && in_in);
            for (int k = 0; k < IO_OUT_NUM; k++)
                if (c_we && in_out && off == 32'(k))
                    out_d[k] = (out_q[k] & ~wmask) | (c_wdata & wmask);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    // Data RAM is deliberately unreset; commit is already low while reset holds the FSM in IDLE
    always_ff @(posedge clk_i)
        if (commit && c_we && in_data)
            mem[c_addr[AW-1:0]] <= (mem_rd & ~wmask) | (c_wdata & wmask);

    for (genvar k = 0; k < IO_OUT_NUM; k++) begin : g_out
        assign io_out_o[32*k +: 32] = out_q[k];
    end
endmodule

// File: tb/tb_lsu_mm.sv
// tb_lsu_mm: directed self-checking bench for lsu_mm at DATA_DEPTH=256, IO_OUT_NUM=11, MEM_LATENCY=2.
module tb_lsu_mm;
    localparam int DD = 256;
    localparam int NO = 11;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [31:0]   req_addr_i = '0;
    logic [31:0]   req_wdata_i = '0;
    logic [3:0]    req_be_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic [31:0]   io_sw_i = '0;
    logic [NO*32-1:0] io_out_o;

    int errors = 0;
    int checks = 0;

    lsu_mm #(.DATA_DEPTH(DD), .IO_OUT_NUM(NO), .MEM_LATENCY(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .io_sw_i(io_sw_i), .io_out_o(io_out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        @(negedge clk_i);
        req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_be_i = be;
        req_valid_i = 1'b1; rsp_ready_i = 1'b0;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0; req_we_i = ~we; req_addr_i = '1; req_wdata_i = 32'h5A5A_5A5A;
        n = 1;
        @(negedge clk_i);
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check({tag, "_rdata"}, rsp_rdata_o, exp_rdata);
        check({tag, "_err"}, 32'(rsp_err_o), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check({tag, "_hold_valid"}, 32'(rsp_valid_o), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata_o, exp_rdata);
            check({tag, "_hold_err"}, 32'(rsp_err_o), 32'(exp_err));
            check({tag, "_hold_ready"}, 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_done_valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] exp7;
        int n;
        repeat (2) @(negedge clk_i);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_err", 32'(rsp_err_o), 32'd0);
        check("rst_io", 32'(io_out_o == '0), 32'd1);
        rst_i = 1'b0;
        #1;
        check("rel_ready_pre", 32'(req_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("rel_ready", 32'(req_ready_o), 32'd1);

        txn("st5", 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, 0, 32'd0, 1'b0);
        txn("ld5", 1'b0, 32'd5, 32'd0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0);

        txn("st_io1", 1'b1, DD + 1, 32'h12, 4'hF, 0, 32'd0, 1'b0);
        check("io1", io_out_o[63:32], 32'h12);
        check("io0", io_out_o[31:0], 32'd0);
        txn("ld_io1", 1'b0, DD + 1, 32'd0, 4'hF, 0, 32'h12, 1'b0);
        txn("ld_io_hi", 1'b0, DD + 20, 32'd0, 4'hF, 0, 32'd0, 1'b0);

        io_sw_i = '1;
        txn("ld_sw", 1'b0, DD + 64, 32'd0, 4'hF, 0, 32'h0001_FFFF, 1'b0);
        txn("st_sw", 1'b1, DD + 64, 32'hCAFE_F00D, 4'hF, 0, 32'd0, 1'b1);
        txn("ld5_again", 1'b0, 32'd5, 32'd0, 4'hF, 0, 32'hDEAD_BEEF, 1'b0);
        check("io1_kept", io_out_o[63:32], 32'h12);

        txn("ld_rsv", 1'b0, 32'h1000, 32'd0, 4'hF, 3, 32'd0, 1'b1);

`ifdef LSU_BYTE_STORE_EN
        exp7 = 32'hAA22_CC44;
`else
        exp7 = 32'h1122_3344;
`endif
        txn("st7", 1'b1, 32'd7, 32'hAABB_CCDD, 4'hF, 0, 32'd0, 1'b0);
        txn("st7_be", 1'b1, 32'd7, 32'h1122_3344, 4'b0101, 0, 32'd0, 1'b0);
        txn("ld7", 1'b0, 32'd7, 32'd0, 4'hF, 0, exp7, 1'b0);

        txn("st9", 1'b1, 32'd9, 32'h77, 4'hF, 0, 32'd0, 1'b0);
        @(negedge clk_i);
        req_we_i = 1'b1; req_addr_i = 32'd9; req_wdata_i = 32'h55; req_be_i = 4'hF; req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("mid_accept", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check("mid_wait_valid", 32'(rsp_valid_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("mid_rst_ready", 32'(req_ready_o), 32'd0);
        check("mid_rst_io", 32'(io_out_o == '0), 32'd1);
        rst_i = 1'b0;
        #1;
        check("mid_rel_pre", 32'(req_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("mid_rel_ready", 32'(req_ready_o), 32'd1);
        check("mid_rel_valid", 32'(rsp_valid_o), 32'd0);
        txn("ld9", 1'b0, 32'd9, 32'd0, 4'hF, 0, 32'h77, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
